// File: rtl/jpeg_block_scheduler_pkg.sv
// Shared types and constants for the JPEG block scheduler and its block buffer.
package jpeg_pkg;

    localparam int unsigned BLOCK_PIXELS = 64;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned PTR_W        = $clog2(BLOCK_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT
    } sched_state_t;

endpackage

// File: rtl/jpeg_block_scheduler_if.sv
// Frame control, pixel source and encoder-core signals of the block scheduler.
interface jpeg_block_scheduler_if
    import jpeg_pkg::*;
#(
    parameter int unsigned BLK_CNT_W = 8
) ();

    logic                 frame_start;
    logic [BLK_CNT_W-1:0] cfg_blocks_x;
    logic [BLK_CNT_W-1:0] cfg_blocks_y;
    logic                 src_valid;
    logic [PIX_W-1:0]     src_pixel;
    logic                 src_ready;
    logic                 core_start;
    logic [PIX_W-1:0]     core_pixel;
    logic                 core_done;
    logic                 busy;
    logic [BLK_CNT_W-1:0] blk_x;
    logic [BLK_CNT_W-1:0] blk_y;
    logic                 frame_done;
    logic                 err_timeout;

    // Environment side: host, pixel source and encoder core.
    modport master (
        output frame_start, cfg_blocks_x, cfg_blocks_y, src_valid, src_pixel, core_done,
        input  src_ready, core_start, core_pixel, busy, blk_x, blk_y, frame_done, err_timeout
    );

    // Scheduler side.
    modport slave (
        input  frame_start, cfg_blocks_x, cfg_blocks_y, src_valid, src_pixel, core_done,
        output src_ready, core_start, core_pixel, busy, blk_x, blk_y, frame_done, err_timeout
    );

endinterface

// File: rtl/jpeg_block_scheduler_buf.sv
// One-block 64x8 pixel buffer: sync write, async read, fill pointer and full flag.
module block_buf_64x8
    import jpeg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_release,
    input  logic             i_wr_en,
    input  logic [PIX_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_ptr,
    output logic [PIX_W-1:0] o_rd_data_c,
    output logic             o_full,
    output logic             o_wrap_c
);

    logic [PIX_W-1:0] r_mem [BLOCK_PIXELS];
    logic [PTR_W-1:0] r_wr_ptr;
    logic             r_full;

    // Storage needs no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin : p_mem
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_fill
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            if (i_release) begin
                r_full <= 1'b0;
            end
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (r_wr_ptr == PTR_W'(BLOCK_PIXELS - 1)) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign o_rd_data_c = r_mem[i_rd_ptr];
    assign o_full      = r_full;
    assign o_wrap_c    = i_wr_en && (r_wr_ptr == PTR_W'(BLOCK_PIXELS - 1));

endmodule

// File: rtl/jpeg_block_scheduler.sv
// Frame-level scheduler: buffers one 8x8 block, bursts it to the encoder core,
// waits for block completion and walks the configured block grid.
module jpeg_block_scheduler
    import jpeg_pkg::*;
#(
    parameter int unsigned BLK_CNT_W = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jpeg_block_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned TOT_W = 2 * BLK_CNT_W;

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [BLK_CNT_W-1:0] r_bx;
    logic [BLK_CNT_W-1:0] r_by;
    logic [TOT_W-1:0]     r_total;
    logic [TOT_W-1:0]     r_blocks_loaded;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_busy;
    logic [BLK_CNT_W-1:0] r_blk_x;
    logic [BLK_CNT_W-1:0] r_blk_y;
    logic                 r_frame_done;
    logic                 r_err_timeout;

    logic                 w_go;
    logic                 w_issue_end;
    logic                 w_adv;
    logic                 w_finish;
    logic                 w_abort;
    logic                 w_last_blk;
    logic                 w_buf_full;
    logic                 w_blk_loaded;
    logic                 w_src_ready;
    logic                 w_wr_en;
    logic [PIX_W-1:0]     w_rd_data;
    logic [BLK_CNT_W-1:0] w_bx_n;
    logic [BLK_CNT_W-1:0] w_by_n;

    // A zero dimension is treated as a single block.
    assign w_bx_n = (bus.cfg_blocks_x == '0) ? BLK_CNT_W'(1) : bus.cfg_blocks_x;
    assign w_by_n = (bus.cfg_blocks_y == '0) ? BLK_CNT_W'(1) : bus.cfg_blocks_y;

    assign w_last_blk = (r_blk_x == r_bx - BLK_CNT_W'(1)) && (r_blk_y == r_by - BLK_CNT_W'(1));
    assign w_src_ready = r_busy && !w_buf_full && (r_blocks_loaded < r_total);
    assign w_wr_en     = bus.src_valid && w_src_ready;

    block_buf_64x8 u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_go | w_abort),
        .i_release   (w_issue_end),
        .i_wr_en     (w_wr_en),
        .i_wr_data   (bus.src_pixel),
        .i_rd_ptr    (r_rd_ptr),
        .o_rd_data_c (w_rd_data),
        .o_full      (w_buf_full),
        .o_wrap_c    (w_blk_loaded)
    );

    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control strobes; core_done wins over the timeout terminal count.
    always_comb begin : p_next
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_issue_end = 1'b0;
        w_adv       = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.frame_start) begin
                    w_go        = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_buf_full) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_rd_ptr == PTR_W'(BLOCK_PIXELS - 1)) begin
                    w_issue_end = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    if (w_last_blk) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_ctrl
        if (!rst_n) begin
            r_bx            <= '0;
            r_by            <= '0;
            r_total         <= '0;
            r_blocks_loaded <= '0;
            r_rd_ptr        <= '0;
            r_wait_cnt      <= '0;
            r_busy          <= 1'b0;
            r_blk_x         <= '0;
            r_blk_y         <= '0;
            r_frame_done    <= 1'b0;
            r_err_timeout   <= 1'b0;
        end else begin
            r_frame_done  <= w_finish;
            r_err_timeout <= w_abort;
            if (w_go) begin
                r_bx            <= w_bx_n;
                r_by            <= w_by_n;
                r_total         <= TOT_W'(w_bx_n) * TOT_W'(w_by_n);
                r_blocks_loaded <= '0;
                r_blk_x         <= '0;
                r_blk_y         <= '0;
                r_busy          <= 1'b1;
            end else begin
                if (w_blk_loaded) begin
                    r_blocks_loaded <= r_blocks_loaded + TOT_W'(1);
                end
                if (w_finish || w_abort) begin
                    r_busy <= 1'b0;
                end
                if (w_adv) begin
                    if (r_blk_x == r_bx - BLK_CNT_W'(1)) begin
                        r_blk_x <= '0;
                        r_blk_y <= r_blk_y + BLK_CNT_W'(1);
                    end else begin
                        r_blk_x <= r_blk_x + BLK_CNT_W'(1);
                    end
                end
            end
            // Read pointer only runs during a burst, so leaving ISSUE (or aborting) rewinds it.
            r_rd_ptr   <= (r_state == S_ISSUE) ? r_rd_ptr + PTR_W'(1) : '0;
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
        end
    end

    assign bus.src_ready   = w_src_ready;
    assign bus.core_start  = (r_state == S_ISSUE) && (r_rd_ptr == '0);
    assign bus.core_pixel  = (r_state == S_ISSUE) ? w_rd_data : '0;
    assign bus.busy        = r_busy;
    assign bus.blk_x       = r_blk_x;
    assign bus.blk_y       = r_blk_y;
    assign bus.frame_done  = r_frame_done;
    assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Scoreboard bench for jpeg_block_scheduler: stimulus queues expected bursts and
// frame events, a negedge monitor pops and compares them as the DUT produces them.
module tb_jpeg_block_scheduler;

    localparam int unsigned BW         = 8;
    localparam int          CORE_DELAY = 20;

    typedef struct {
        int cyc;
        int x;
        int y;
    } start_t;

    typedef struct {
        int kind;
        int cyc;
    } evt_t;

    logic clk;
    logic rst_n;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    int   done_at = -1;
    int   last_done_cyc = -100;
    int   burst   = 0;
    int   blkn    = 0;
    bit   core_en = 1'b1;

    start_t     exp_start_q[$];
    logic [7:0] exp_pix_q[$];
    evt_t       exp_evt_q[$];

    jpeg_block_scheduler_if #(.BLK_CNT_W(BW)) bus ();

    jpeg_block_scheduler #(.BLK_CNT_W(BW), .TIMEOUT(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] pix_val(input int b, input int i);
        return 8'((b * 29 + i * 7 + 3) % 256);
    endfunction

    // Core model: one done pulse CORE_DELAY cycles after the last pixel of a burst.
    initial begin
        bus.core_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.core_done = core_en && (cyc == done_at);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            burst   = 0;
            done_at = -1;
            exp_pix_q.delete();
        end else begin
            if (bus.core_done) last_done_cyc = cyc;
            if (bus.core_start) begin
                start_t e;
                chk("start_inside_burst", burst, 0);
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_core_start", 1, 0);
                end else begin
                    e = exp_start_q.pop_front();
                    if (e.cyc >= 0) chk("core_start_cycle", cyc, e.cyc);
                    chk("blk_x_at_start", bus.blk_x, e.x);
                    chk("blk_y_at_start", bus.blk_y, e.y);
                end
                burst   = 64;
                done_at = cyc + 63 + CORE_DELAY;
            end
            if (burst > 0) begin
                if (exp_pix_q.size() == 0) chk("unexpected_pixel", 1, 0);
                else chk("core_pixel", bus.core_pixel, exp_pix_q.pop_front());
                burst--;
            end
            if (bus.frame_done || bus.err_timeout) begin
                evt_t ev;
                chk("busy_at_event", bus.busy, 0);
                if (exp_evt_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    ev = exp_evt_q.pop_front();
                    chk("event_kind", bus.frame_done ? 1 : 2, ev.kind);
                    if (ev.cyc >= 0) chk("event_cycle", cyc, ev.cyc);
                    else chk("frame_done_after_core_done", cyc, last_done_cyc + 1);
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_src_ready"}, bus.src_ready, 0);
        chk({tag, "_core_start"}, bus.core_start, 0);
        chk({tag, "_core_pixel"}, bus.core_pixel, 0);
        chk({tag, "_blk_x"}, bus.blk_x, 0);
        chk({tag, "_blk_y"}, bus.blk_y, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_err_timeout"}, bus.err_timeout, 0);
    endtask

    task automatic push_pixels(input int nb, input int b0);
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < 64; i++)
                exp_pix_q.push_back(pix_val(b0 + b, i));
    endtask

    // Feeds nb blocks; gappy drops src_valid on every fifth cycle.
    task automatic send_pixels(input int nb, input int b0, input bit gappy);
        int sent = 0;
        int k    = 0;
        while (sent < nb * 64 && k < 20000) begin
            bus.src_valid = gappy ? ((k % 5) != 3) : 1'b1;
            bus.src_pixel = pix_val(b0 + sent / 64, sent % 64);
            @(negedge clk);
            if (bus.src_valid && bus.src_ready) sent++;
            @(posedge clk);
            #1;
            k++;
        end
        bus.src_valid = 1'b0;
        chk("src_pixels_accepted", sent, nb * 64);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < budget);
        chk({tag, "_busy_end"}, bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] cx, input logic [7:0] cy);
        bus.frame_start  = 1'b1;
        bus.cfg_blocks_x = cx;
        bus.cfg_blocks_y = cy;
        @(posedge clk);
        #1;
        bus.frame_start  = 1'b0;
        bus.cfg_blocks_x = 8'd0;
        bus.cfg_blocks_y = 8'd0;
    endtask

    // mode 0: normal frame, 1: core never answers, 2: reset at rd_ptr=30.
    task automatic run_1x1(input logic [7:0] cx, input logic [7:0] cy, input int mode, input string tag);
        int t = cyc;
        evt_t ev;
        exp_start_q.push_back('{cyc: t + 66, x: 0, y: 0});
        push_pixels(1, blkn);
        core_en = (mode != 1);
        if (mode == 0) begin
            ev = '{kind: 1, cyc: t + 150};
            exp_evt_q.push_back(ev);
        end else if (mode == 1) begin
            ev = '{kind: 2, cyc: t + 230};
            exp_evt_q.push_back(ev);
        end
        pulse_start(cx, cy);
        chk({tag, "_busy_t1"}, bus.busy, 1);
        chk({tag, "_src_ready_t1"}, bus.src_ready, 1);
        send_pixels(1, blkn, 1'b0);
        blkn++;
        if (mode == 2) begin
            while (cyc < t + 96) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            #1;
            check_idle({tag, "_async_rst"});
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            wait_idle(400, tag);
        end
        core_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        evt_t ev;
        rst_n            = 1'b0;
        bus.frame_start  = 1'b0;
        bus.cfg_blocks_x = 8'd0;
        bus.cfg_blocks_y = 8'd0;
        bus.src_valid    = 1'b0;
        bus.src_pixel    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_1x1(8'd1, 8'd1, 0, "f1x1");

        // 3x2 frame with source gaps; coordinates walk row by row.
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 3; x++)
                exp_start_q.push_back('{cyc: -1, x: x, y: y});
        push_pixels(6, blkn);
        ev = '{kind: 1, cyc: -1};
        exp_evt_q.push_back(ev);
        pulse_start(8'd3, 8'd2);
        send_pixels(6, blkn, 1'b1);
        blkn += 6;
        wait_idle(2000, "f3x2");

        run_1x1(8'd1, 8'd1, 1, "timeout");
        run_1x1(8'd1, 8'd1, 0, "after_timeout");

        // 2x1 frame with a conflicting frame_start mid-load.
        exp_start_q.push_back('{cyc: -1, x: 0, y: 0});
        exp_start_q.push_back('{cyc: -1, x: 1, y: 0});
        push_pixels(2, blkn);
        ev = '{kind: 1, cyc: -1};
        exp_evt_q.push_back(ev);
        pulse_start(8'd2, 8'd1);
        fork
            send_pixels(2, blkn, 1'b0);
            begin
                repeat (30) @(posedge clk);
                #1;
                pulse_start(8'd5, 8'd5);
            end
        join
        blkn += 2;
        wait_idle(1000, "restart_ignored");

        run_1x1(8'd1, 8'd1, 2, "mid_reset");
        check_idle("post_reset");
        run_1x1(8'd1, 8'd1, 0, "after_reset");
        run_1x1(8'd0, 8'd0, 0, "cfg_zero");

        repeat (5) @(posedge clk);
        #1;
        chk("leftover_starts", exp_start_q.size(), 0);
        chk("leftover_pixels", exp_pix_q.size(), 0);
        chk("leftover_events", exp_evt_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_block_scheduler.md
# jpeg_block_scheduler

Frame-level controller in front of the 8x8 JPEG encoder core (DCT -> quantizer -> entropy encoder). It accepts a raster-of-blocks pixel stream from a stalling source and buffers one full 8x8 block. It then issues `core_start` and streams the 64 pixels to the core on 64 consecutive cycles, waits for the core's block `done`, and repeats for every block of the configured frame. It tracks block coordinates, reports frame completion, and aborts on a core timeout.

## Interface
Parameters:
- `BLK_CNT_W`, default 8: width of the block-count config and coordinate outputs.
- `TIMEOUT`, default 1023: max cycles in WAIT before abort; counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; ignored unless `busy`=0.
- `cfg_blocks_x` in BLK_CNT_W: blocks per row, sampled at `frame_start`; 0 is treated as 1.
- `cfg_blocks_y` in BLK_CNT_W: block rows, sampled at `frame_start`; 0 is treated as 1.
- `src_valid` in 1: source pixel valid.
- `src_pixel` in 8: unsigned pixel, block-raster order (64 per block, row-major within block).
- `src_ready` out 1: scheduler accepts the pixel when `src_valid && src_ready`.
- `core_start` out 1: one-cycle pulse to core `start`.
- `core_pixel` out 8: to core `pixel_in`.
- `core_done` in 1: core block-done pulse.
- `busy` out 1: frame in progress.
- `blk_x`, `blk_y` out BLK_CNT_W: coordinates of the block currently issued or awaited.
- `frame_done` out 1: one-cycle pulse after the last block's `core_done`.
- `err_timeout` out 1: one-cycle pulse on WAIT timeout.

All outputs reset to 0.

## Operation
- Buffer: 64x8 storage, write pointer `wr_ptr` (0..63), read pointer `rd_ptr` (0..63), flag `buf_full`.
- Fill side:
  - `src_ready = busy && !buf_full && (blocks_loaded < total)`.
  - Each accepted pixel is written at `wr_ptr`, then `wr_ptr++`.
  - The 64th write sets `buf_full`, wraps `wr_ptr` to 0 and increments `blocks_loaded`.
- Issue FSM states: IDLE, LOAD, ISSUE, WAIT.
  - IDLE: on `frame_start`, latch cfg and set `total = bx*by`. Clear counters, `blk_x`, `blk_y` and `blocks_loaded`; set `busy=1`; go to LOAD.
  - LOAD: when `buf_full`=1, go to ISSUE. `core_start` is driven in the first ISSUE cycle.
  - ISSUE: 64 cycles, `core_pixel = buf[rd_ptr]`, `rd_ptr++`.
    - `core_start`=1 only when `rd_ptr`=0.
    - At `rd_ptr`=63: clear `buf_full` and go to WAIT. The next block fill may start on the following cycle.
  - WAIT: count cycles.
    - On `core_done`: if the block was the last (`blk_x=bx-1 && blk_y=by-1`), pulse `frame_done`, clear `busy` and go to IDLE.
    - Otherwise advance coordinates (`blk_x++`; at `bx-1` wrap to 0 and `blk_y++`) and go to LOAD.
    - If the count reaches TIMEOUT without `core_done`: pulse `err_timeout`, clear `busy`, `buf_full` and pointers, and go to IDLE. The remaining source pixels are not consumed.
- `core_done` outside WAIT is ignored.
- `core_pixel` is 0 outside ISSUE.
- `frame_start` while `busy` is ignored (no re-latch).

## Timing
- `frame_start` at cycle T: `busy`=1 and `src_ready`=1 at T+1.
- With `src_valid` held high, 64 pixels are accepted in cycles T+1..T+64.
- `core_start` and pixel 0 are at T+66 (LOAD sees `buf_full` at T+65). Pixels 1..63 follow at T+67..T+129.
- `src_ready` reasserts at T+130 (overlap of next fill with WAIT).
- Simultaneous `core_done` and timeout terminal count: `core_done` wins.
- `core_done` on the first WAIT cycle is valid.
- A 64th fill write in the same cycle LOAD samples `buf_full` is seen the next cycle (no combinational bypass).
- `frame_done` is asserted in the cycle after `core_done`; `busy` falls the same cycle.
- `rst_n` low mid-frame: immediate return to IDLE, all outputs 0, buffer contents don't-care.

## Structure
- Shared package `jpeg_pkg`: `BLOCK_PIXELS=64`, the state enum `sched_state_t`, and the pixel width `PIX_W=8`.
- One natural sub-module: `block_buf_64x8`, a simple dual-port register buffer (sync write, async read), holding the fill pointer logic and `buf_full`.
- FSM, coordinate counters and timeout live in the top.

## Test plan
- 1x1 frame, source always valid, core model asserts done 20 cycles after last pixel -> exactly one `core_start` at T+66, 64 contiguous `core_pixel` matching input, `frame_done` one cycle after done.
- 3x2 frame with random `src_valid` gaps -> 6 `core_start` pulses; `blk_x/blk_y` sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); no gaps inside any 64-pixel burst.
- Core never asserts done, TIMEOUT=100 -> `err_timeout` pulse exactly 100 cycles into WAIT; `busy`=0; next `frame_start` runs a clean frame.
- `frame_start` pulsed mid-frame with different cfg -> ignored; original block count completes.
- `rst_n` asserted during ISSUE at `rd_ptr`=30 -> all outputs 0 asynchronously; after release, a fresh 1x1 frame behaves as the first scenario.
- `cfg_blocks_x`=0, `cfg_blocks_y`=0 -> processed as 1x1; single `frame_done`.
